byte_packer: RTL and testbench
==============================

// Module: byte_packer
// PURPOSE
//  Upstream feeder for the padder stage. Takes a message as a byte stream
//  with a valid/ready handshake plus a separate end-of-message handshake.
//  Packs the bytes into 64-bit words and drives the padder's word interface
//  (in, in_ready, is_last, byte_num, ack).
//  Handles one message per reset; after the final word it idles until reset.
// PARAMETERS
//  BIG_FIRST  1  1: first byte of a word goes in [63:56]; 0: in [7:0]. Must be 1 when driving padder.
// PORTS
//  clk         in   1   clock
//  reset       in   1   synchronous, active-high reset
//  byte_in     in   8   message byte
//  byte_valid  in   1   byte_in is valid
//  byte_ready  out  1   byte accepted this cycle when byte_valid & byte_ready
//  end_msg     in   1   no more bytes; held high until end_ack
//  end_ack     out  1   end_msg accepted this cycle
//  word_out    out  64  packed word -> padder in
//  word_valid  out  1   word_out valid -> padder in_ready
//  word_last   out  1   final word of message -> padder is_last
//  word_bytes  out  3   valid bytes in final word, 0..7 -> padder byte_num
//  word_ack    in   1   padder took the word (ack)
// BEHAVIOUR
//  - Datapath: accumulator acc[63:0] with count cnt[2:0] (0..7).
//    Output slot holds slot_word, slot_valid, slot_last, slot_num.
//  - FSM states: FILL -> FLUSH -> DONE.
//  - Reset: state=FILL, acc=0, cnt=0, slot cleared.
//    All outputs 0 except byte_ready=1.
//  - byte_ready = FILL & ~(cnt==7 & slot_valid).
//  - Byte accepted with cnt<7: byte goes in lane cnt (lane 0 = [63:56] when
//    BIG_FIRST), then cnt++.
//  - Byte accepted with cnt==7 (slot is free): slot_word = acc plus byte in
//    lane 7, slot_valid=1, slot_last=0. Then acc=0, cnt=0.
//  - end_ack = FILL & end_msg & ~byte_valid & ~slot_valid. Bytes win over end.
//  - On end_ack: slot_word = acc (unfilled lanes zero), slot_last=1,
//    slot_num=cnt, slot_valid=1. Then acc=0, cnt=0, state=FLUSH.
//  - Empty message or length multiple of 8: end_ack occurs with cnt=0, giving
//    an all-zero last word with word_bytes=0.
//  - word_valid=slot_valid; word_last=slot_valid&slot_last.
//    word_bytes=slot_last?slot_num:0.
//  - word_out is 0 when slot is empty.
//  - Slot clears (slot_valid=0) the cycle after word_valid & word_ack.
//    No refill in the ack cycle, so there is a one-cycle bubble at most.
//  - Slot contents stay stable while word_valid & ~word_ack.
//    word_last never goes high without word_valid.
//  - FLUSH: byte_ready=0, end_ack=0. On word_ack: state=DONE.
//  - DONE: byte_ready=0, end_ack=0, word_valid=0. Stays there until reset.
//  - Inputs are ignored outside FILL. word_ack with slot empty is ignored.
//  - Reset mid-message drops everything: acc, cnt, slot and state back to
//    reset values. The next byte lands in lane 0.
//  - Latency: a full word appears in the slot 1 cycle after its 8th byte.
//    The last word appears 1 cycle after end_ack.
// TESTING
//  1. Reset held 2 cycles -> word_valid=0, word_last=0, word_bytes=0,
//     end_ack=0, byte_ready=1.
//  2. Bytes 01..08, then end_msg, word_ack=1 -> word 0x0102030405060708 with
//     last=0; then word 0 with last=1, bytes=0; then DONE, byte_ready=0.
//  3. Bytes AA,BB,CC then end_msg -> word 0xAABBCC0000000000, last=1,
//     bytes=3; after ack, byte_ready stays 0.
//  4. end_msg straight after reset -> word 0, last=1, bytes=0.
//     byte_valid asserted afterwards is never accepted.
//  5. word_ack=0, 16 bytes 00..0F offered -> slot holds 0x0001020304050607.
//     Bytes 08..0E are accepted; byte_ready=0 on 0F until word_ack.
//     Next word is 0x08090A0B0C0D0E0F; no byte lost.
//  6. Reset after 5 bytes, then bytes 11,22 and end_msg -> word
//     0x1122000000000000, bytes=2; earlier bytes absent.

Source files
------------

// File: rtl/byte_packer_if.sv
// Byte-stream, end-of-message and packed-word handshakes of the byte packer.
// Latency: none (signal bundle only).
// Backpressure: byte_ready / end_ack / word_ack carry the flow control.
//   slave  : the packer (takes bytes and end_msg, drives the word side)
//   master : the byte source / word sink facing the packer
interface byte_packer_if;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        end_msg;
   logic        end_ack;
   logic [63:0] word_out;
   logic        word_valid;
   logic        word_last;
   logic [2:0]  word_bytes;
   logic        word_ack;

   modport slave (
      input  byte_in, byte_valid, end_msg, word_ack,
      output byte_ready, end_ack, word_out, word_valid, word_last, word_bytes
   );

   modport master (
      output byte_in, byte_valid, end_msg, word_ack,
      input  byte_ready, end_ack, word_out, word_valid, word_last, word_bytes
   );
endinterface

// File: rtl/byte_packer.sv
// Packs one message byte stream into 64-bit words for the padder; one message per reset.
// Latency: full word 1 cycle after its 8th byte; last word 1 cycle after end_ack.
// Backpressure: stalls bytes only when 7 bytes are held and the output slot is full.
//   clk, reset : clock, synchronous active-high reset
//   bus.slave  : byte_in/byte_valid/byte_ready, end_msg/end_ack,
//                word_out/word_valid/word_last/word_bytes/word_ack
module byte_packer #(
   parameter bit BIG_FIRST = 1'b1   // 1: first byte of a word in [63:56]
) (
   input  logic          clk,
   input  logic          reset,
   byte_packer_if.slave  bus
);
   typedef enum logic [1:0] {FILL, FLUSH, DONE} state_t;

   state_t      state_q, state_d;
   logic [63:0] acc_q, acc_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [63:0] slot_word_q, slot_word_d;
   logic        slot_valid_q, slot_valid_d;
   logic        slot_last_q, slot_last_d;
   logic [2:0]  slot_num_q, slot_num_d;

   logic        byte_rdy;
   logic        end_rdy;
   logic        byte_take;
   logic        word_take;
   logic [2:0]  lane_sel;
   logic [5:0]  lane_lo;
   logic [63:0] acc_ins;

   // Lane cnt counts from the top byte when BIG_FIRST (~cnt == 7-cnt).
   always_comb begin
      lane_sel = BIG_FIRST ? ~cnt_q : cnt_q;
      lane_lo  = {lane_sel, 3'b000};
      acc_ins  = acc_q;
      acc_ins[lane_lo +: 8] = bus.byte_in;
   end

   // The 8th byte may only enter when the slot is free to take the word.
   assign byte_rdy  = (state_q == FILL) && !((cnt_q == 3'd7) && slot_valid_q);
   // Pending bytes take priority over the end request.
   assign end_rdy   = (state_q == FILL) && bus.end_msg && !bus.byte_valid && !slot_valid_q;
   assign byte_take = bus.byte_valid && byte_rdy;
   assign word_take = slot_valid_q && bus.word_ack;

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      slot_word_d  = slot_word_q;
      slot_valid_d = slot_valid_q;
      slot_last_d  = slot_last_q;
      slot_num_d   = slot_num_q;

      // Clear the whole slot on acceptance; refill waits for the next cycle
      // because both load paths require an empty slot as seen this cycle.
      if (word_take) begin
         slot_word_d  = '0;
         slot_valid_d = 1'b0;
         slot_last_d  = 1'b0;
         slot_num_d   = 3'd0;
         if (state_q == FLUSH) begin
            state_d = DONE;
         end
      end

      if (byte_take) begin
         if (cnt_q == 3'd7) begin
            slot_word_d  = acc_ins;
            slot_valid_d = 1'b1;
            slot_last_d  = 1'b0;
            slot_num_d   = 3'd0;
            acc_d        = '0;
            cnt_d        = 3'd0;
         end else begin
            acc_d = acc_ins;
            cnt_d = cnt_q + 3'd1;
         end
      end else if (end_rdy) begin
         // Unfilled lanes are already zero in the accumulator.
         slot_word_d  = acc_q;
         slot_valid_d = 1'b1;
         slot_last_d  = 1'b1;
         slot_num_d   = cnt_q;
         acc_d        = '0;
         cnt_d        = 3'd0;
         state_d      = FLUSH;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= FILL;
         acc_q        <= '0;
         cnt_q        <= 3'd0;
         slot_word_q  <= '0;
         slot_valid_q <= 1'b0;
         slot_last_q  <= 1'b0;
         slot_num_q   <= 3'd0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         slot_word_q  <= slot_word_d;
         slot_valid_q <= slot_valid_d;
         slot_last_q  <= slot_last_d;
         slot_num_q   <= slot_num_d;
      end
   end

   assign bus.byte_ready = byte_rdy;
   assign bus.end_ack    = end_rdy;
   assign bus.word_out   = slot_valid_q ? slot_word_q : 64'd0;
   assign bus.word_valid = slot_valid_q;
   assign bus.word_last  = slot_valid_q && slot_last_q;
   assign bus.word_bytes = (slot_valid_q && slot_last_q) ? slot_num_q : 3'd0;
endmodule

// File: tb/tb_byte_packer.sv
module tb_byte_packer;
   logic clk = 1'b0;
   logic reset = 1'b1;

   byte_packer_if bus();

   byte_packer #(.BIG_FIRST(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [63:0] w;
      logic        l;
      logic [2:0]  n;
   } wrec_t;

   wrec_t got_w[$];   // words handed over (word_valid & word_ack)

   task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Message-level view: bytes waiting to form a word, one pending output word.
   typedef enum {M_FILL, M_FLUSH, M_DONE} mphase_t;
   mphase_t     m_phase;
   logic [7:0]  m_pend[$];
   bit          m_full;
   logic [63:0] m_word;
   bit          m_last;
   int          m_num;
   bit          model_ok = 0;

   function automatic logic [63:0] pack(input logic [7:0] q[$]);
      logic [63:0] w = 64'd0;
      for (int i = 0; i < q.size(); i++) w = w | (64'(q[i]) << (56 - 8 * i));
      return w;
   endfunction

   always @(negedge clk) begin
      bit e_rdy, e_ack;
      e_rdy = (m_phase == M_FILL) && !(m_pend.size() == 7 && m_full);
      e_ack = (m_phase == M_FILL) && bus.end_msg && !bus.byte_valid && !m_full;
      if (model_ok) begin
         chk("byte_ready", 68'(bus.byte_ready), 68'(e_rdy));
         chk("end_ack",    68'(bus.end_ack),    68'(e_ack));
         chk("word_valid", 68'(bus.word_valid), 68'(m_full));
         chk("word_out",   68'(bus.word_out),   68'(m_full ? m_word : 64'd0));
         chk("word_last",  68'(bus.word_last),  68'(m_full && m_last));
         chk("word_bytes", 68'(bus.word_bytes), 68'((m_full && m_last) ? m_num : 0));
         if (!reset && bus.word_valid && bus.word_ack)
            got_w.push_back({bus.word_out, bus.word_last, bus.word_bytes});
      end
      if (reset) begin
         m_phase = M_FILL; m_pend.delete(); m_full = 0;
         m_word = 64'd0; m_last = 0; m_num = 0; model_ok = 1;
      end else if (model_ok) begin
         if (m_full && bus.word_ack) begin
            m_full = 0;
            if (m_last) m_phase = M_DONE;
         end
         if (bus.byte_valid && e_rdy) begin
            m_pend.push_back(bus.byte_in);
            if (m_pend.size() == 8) begin
               m_word = pack(m_pend); m_full = 1; m_last = 0; m_num = 0;
               m_pend.delete();
            end
         end else if (e_ack) begin
            m_word = pack(m_pend); m_full = 1; m_last = 1; m_num = m_pend.size();
            m_pend.delete(); m_phase = M_FLUSH;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      bus.byte_valid = 0; bus.end_msg = 0; bus.word_ack = 0; bus.byte_in = 8'h00;
      reset = 1;
      cyc(n);
      reset = 0;
      got_w.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit done = 0;
      bus.byte_in = b; bus.byte_valid = 1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk); done = bus.byte_ready;
         @(posedge clk); #1;
      end
      bus.byte_valid = 0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL send_byte_timeout: byte %h not accepted within 50 cycles", b);
      end
   endtask

   task automatic send_end();
      bit done = 0;
      bus.end_msg = 1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk); done = bus.end_ack;
         @(posedge clk); #1;
      end
      bus.end_msg = 0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL send_end_timeout: end_msg not acknowledged within 50 cycles");
      end
   endtask

   task automatic chk_word(input string nm, input int idx, input logic [63:0] w,
                           input logic l, input logic [2:0] n);
      if (idx < got_w.size()) chk(nm, got_w[idx], {w, l, n});
      else begin
         checks++; errors++;
         $display("FAIL %s: got no word %0d (only %0d) expected %h", nm, idx, got_w.size(), w);
      end
   endtask

   initial begin
      bus.byte_in = 8'h00; bus.byte_valid = 0; bus.end_msg = 0; bus.word_ack = 0;

      // 1: reset state
      do_reset(2);
      @(negedge clk);
      chk("t1_word_valid", 68'(bus.word_valid), 68'd0);
      chk("t1_word_last",  68'(bus.word_last),  68'd0);
      chk("t1_word_bytes", 68'(bus.word_bytes), 68'd0);
      chk("t1_end_ack",    68'(bus.end_ack),    68'd0);
      chk("t1_byte_ready", 68'(bus.byte_ready), 68'd1);
      cyc(1);

      // 2: exactly eight bytes, then end
      do_reset(2);
      bus.word_ack = 1;
      for (int i = 1; i <= 8; i++) send_byte(8'(i));
      send_end();
      cyc(5);
      chk("t2_nwords", 68'(got_w.size()), 68'd2);
      chk_word("t2_w0", 0, 64'h0102030405060708, 1'b0, 3'd0);
      chk_word("t2_w1", 1, 64'h0, 1'b1, 3'd0);
      @(negedge clk);
      chk("t2_ready_done", 68'(bus.byte_ready), 68'd0);
      cyc(1);

      // 3: short message
      do_reset(1);
      bus.word_ack = 1;
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
      send_end();
      cyc(4);
      chk("t3_nwords", 68'(got_w.size()), 68'd1);
      chk_word("t3_w0", 0, 64'hAABBCC0000000000, 1'b1, 3'd3);
      @(negedge clk);
      chk("t3_ready_done", 68'(bus.byte_ready), 68'd0);
      cyc(1);

      // 4: empty message, later bytes refused
      do_reset(1);
      bus.word_ack = 1;
      send_end();
      cyc(4);
      bus.byte_in = 8'h55; bus.byte_valid = 1;
      cyc(4);
      @(negedge clk);
      chk("t4_ready_done", 68'(bus.byte_ready), 68'd0);
      cyc(1);
      bus.byte_valid = 0;
      chk("t4_nwords", 68'(got_w.size()), 68'd1);
      chk_word("t4_w0", 0, 64'h0, 1'b1, 3'd0);

      // 5: backpressure with word_ack low
      do_reset(1);
      for (int i = 0; i < 15; i++) send_byte(8'(i));
      bus.byte_in = 8'h0F; bus.byte_valid = 1;
      cyc(3);
      @(negedge clk);
      chk("t5_ready_stall", 68'(bus.byte_ready), 68'd0);
      chk("t5_slot_word",   68'(bus.word_out),   68'h0001020304050607);
      chk("t5_none_taken",  68'(got_w.size()),   68'd0);
      cyc(1);
      bus.word_ack = 1;
      send_byte(8'h0F);
      send_end();
      cyc(5);
      chk("t5_nwords", 68'(got_w.size()), 68'd3);
      chk_word("t5_w0", 0, 64'h0001020304050607, 1'b0, 3'd0);
      chk_word("t5_w1", 1, 64'h08090A0B0C0D0E0F, 1'b0, 3'd0);
      chk_word("t5_w2", 2, 64'h0, 1'b1, 3'd0);

      // 6: reset mid-message discards earlier bytes
      do_reset(1);
      bus.word_ack = 1;
      for (int i = 0; i < 5; i++) send_byte(8'hE0 + 8'(i));
      do_reset(1);
      bus.word_ack = 1;
      send_byte(8'h11); send_byte(8'h22);
      send_end();
      cyc(4);
      chk("t6_nwords", 68'(got_w.size()), 68'd1);
      chk_word("t6_w0", 0, 64'h1122000000000000, 1'b1, 3'd2);

      cyc(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
